// File: rtl/reflex_round_ctrl.sv
// reflex_round_ctrl -- game sequencer for the reflex reaction game.
// Runs one timed game per start pulse: arm, pseudo-random delay, light a
// target LED, judge the switch response, keep score and a seconds countdown.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   start       single-cycle start pulse (already synchronised)
//   sw[15:0]    player switches, sw[i] answers led[i]
//   led[15:0]   target / status LEDs (registered)
//   timer_out   seconds remaining (registered)
//   score_out   hits this game, saturating at 63 (registered)
//   target_idx  current target index (registered)
//   busy        high in ARM/DELAY/SHOW (registered)
//   game_over   high in OVER (registered)
module reflex_round_ctrl #(
   parameter int TICK_DIV   = 100000,
   parameter int MS_PER_SEC = 1000,
   parameter int GAME_SECS  = 60,
   parameter int DELAY_MIN  = 300,
   parameter int REACT_MS   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] sw,
   output logic [15:0] led,
   output logic [5:0]  timer_out,
   output logic [5:0]  score_out,
   output logic [3:0]  target_idx,
   output logic        busy,
   output logic        game_over
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SEC_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
   localparam int DLY_W = $clog2(DELAY_MIN + 16);
   localparam int RCT_W = $clog2(REACT_MS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(MS_PER_SEC - 1);
   localparam logic [RCT_W-1:0] RCT_LAST = RCT_W'(REACT_MS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      DELAY = 3'd2,
      SHOW  = 3'd3,
      OVER  = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [15:0]      lfsr;
   logic [DIV_W-1:0] div_cnt, div_n;
   logic [SEC_W-1:0] sec_cnt, sec_n;
   logic [DLY_W-1:0] dly_cnt, dly_n;
   logic [RCT_W-1:0] rct_cnt, rct_n;
   logic [5:0]       timer_n, score_n;
   logic [3:0]       tgt_n;
   logic [15:0]      led_n;

   logic             running, ms_tick, sec_done, expire, hit;
   logic [DLY_W-1:0] dly_load;

   assign running  = (state == ARM) || (state == DELAY) || (state == SHOW);
   assign ms_tick  = running && (div_cnt == DIV_LAST);
   assign sec_done = ms_tick && (sec_cnt == SEC_LAST);
   // Timer hitting zero ends the game on the same edge it reaches zero.
   assign expire   = running && ((timer_out == 6'd0) ||
                                 (sec_done && timer_out == 6'd1));
   assign hit      = (state == SHOW) && (sw == (16'd1 << target_idx));
   assign dly_load = DLY_W'(DELAY_MIN) + DLY_W'(lfsr[3:0]);

   always_comb begin
      state_n = state;
      div_n   = running ? ((div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1)) : '0;
      sec_n   = sec_cnt;
      dly_n   = dly_cnt;
      rct_n   = rct_cnt;
      timer_n = timer_out;
      score_n = score_out;
      tgt_n   = target_idx;

      if (sec_done) begin
         sec_n   = '0;
         timer_n = (timer_out != 6'd0) ? timer_out - 6'd1 : 6'd0;
      end else if (ms_tick) begin
         sec_n = sec_cnt + SEC_W'(1);
      end

      case (state)
         IDLE, OVER: begin
            if (start) begin
               state_n = ARM;
               score_n = 6'd0;
               timer_n = 6'(GAME_SECS);
               sec_n   = '0;
            end
         end
         ARM: begin
            // Anti-hold: no round starts while any switch is still up.
            if (sw == 16'd0) begin
               state_n = DELAY;
               tgt_n   = lfsr[7:4];
               dly_n   = dly_load;
            end
         end
         DELAY: begin
            // False start restarts the wait with a fresh random length.
            if (sw != 16'd0)
               dly_n = dly_load;
            else if (dly_cnt == '0) begin
               state_n = SHOW;
               rct_n   = '0;
            end else if (ms_tick)
               dly_n = dly_cnt - DLY_W'(1);
         end
         SHOW: begin
            if (ms_tick && rct_cnt != RCT_LAST)
               rct_n = rct_cnt + RCT_W'(1);
            // Hit is checked first so it wins over a same-cycle timeout.
            if (hit) begin
               state_n = ARM;
               score_n = (score_out == 6'd63) ? score_out : score_out + 6'd1;
            end else if (sw != 16'd0 || rct_cnt == RCT_LAST)
               state_n = ARM;
         end
         default: state_n = IDLE;
      endcase

      if (expire) begin
         state_n = OVER;
         timer_n = 6'd0;
      end

      // Outputs are registered, so they are decoded from the next state.
      case (state_n)
         SHOW:    led_n = 16'd1 << tgt_n;
         OVER:    led_n = 16'hFFFF;
         default: led_n = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         lfsr       <= 16'hACE1;
         div_cnt    <= '0;
         sec_cnt    <= '0;
         dly_cnt    <= '0;
         rct_cnt    <= '0;
         timer_out  <= 6'd0;
         score_out  <= 6'd0;
         target_idx <= 4'd0;
         led        <= 16'h0000;
         busy       <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state      <= state_n;
         // Taps 16,14,13,11; a nonzero seed never reaches the all-zero state.
         lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         div_cnt    <= div_n;
         sec_cnt    <= sec_n;
         dly_cnt    <= dly_n;
         rct_cnt    <= rct_n;
         timer_out  <= timer_n;
         score_out  <= score_n;
         target_idx <= tgt_n;
         led        <= led_n;
         busy       <= (state_n == ARM) || (state_n == DELAY) || (state_n == SHOW);
         game_over  <= (state_n == OVER);
      end
   end

endmodule
